// File: rtl/aligner_exchange_shift_pipe.sv
// Two-stage operand exchange and alignment pipeline for the floating-point aligner.
// Stage 1 orders the operands by magnitude. The larger one becomes A. The stage
// also registers the exponent difference. Stage 2 right-aligns the smaller
// fraction and appends guard, round and sticky bits.
//
// Ports:
//   clk, reset (async, active-high), flush (sync, clears both stages)
//   in_valid/in_ready   : operand-pair handshake (in_ready is combinational)
//   in_sign/exponent/fraction_{a,b} : unpacked operands
//   out_valid/out_ready : result handshake
//   out_exchanged, out_sign_a, out_exponent, out_fraction_a,
//   out_sign_b, out_fraction_b, out_exp_diff : aligned result
//
// Optional build macro: ALIGNER_STICKY_EN. When it is defined, out_fraction_b[0]
// also ORs in every bit shifted out. When it is undefined, the shift simply truncates.
module aligner_exchange_shift_pipe #(
    parameter  int unsigned EXP_WIDTH  = 8,
    parameter  int unsigned FRAC_WIDTH = 24,
    localparam int unsigned EXT_WIDTH  = FRAC_WIDTH + 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign_a,
    input  logic [EXP_WIDTH-1:0]  in_exponent_a,
    input  logic [FRAC_WIDTH-1:0] in_fraction_a,
    input  logic                  in_sign_b,
    input  logic [EXP_WIDTH-1:0]  in_exponent_b,
    input  logic [FRAC_WIDTH-1:0] in_fraction_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_exchanged,
    output logic                  out_sign_a,
    output logic [EXP_WIDTH-1:0]  out_exponent,
    output logic [EXT_WIDTH-1:0]  out_fraction_a,
    output logic                  out_sign_b,
    output logic [EXT_WIDTH-1:0]  out_fraction_b,
    output logic [EXP_WIDTH-1:0]  out_exp_diff
);

    // Stage 1 registers
    logic                  s1_valid;
    logic                  s1_exchanged;
    logic                  s1_sign_a;
    logic                  s1_sign_b;
    logic [EXP_WIDTH-1:0]  s1_exponent;
    logic [EXP_WIDTH-1:0]  s1_exp_diff;
    logic [FRAC_WIDTH-1:0] s1_fraction_a;
    logic [FRAC_WIDTH-1:0] s1_fraction_b;

    // Handshake
    logic stage2_ready;
    logic accept;
    logic advance;

    assign stage2_ready = !out_valid || out_ready;
    assign in_ready     = !s1_valid || stage2_ready;
    assign accept       = in_valid && in_ready;
    assign advance      = s1_valid && stage2_ready;

    // Magnitude compare and operand sort
    logic                  exchange;
    logic                  sort_sign_a;
    logic                  sort_sign_b;
    logic [EXP_WIDTH-1:0]  sort_exp_a;
    logic [EXP_WIDTH-1:0]  sort_exp_b;
    logic [FRAC_WIDTH-1:0] sort_frac_a;
    logic [FRAC_WIDTH-1:0] sort_frac_b;

    always_comb begin
        exchange    = (in_exponent_b > in_exponent_a) ||
                      ((in_exponent_b == in_exponent_a) && (in_fraction_b > in_fraction_a));
        sort_sign_a = in_sign_a;
        sort_sign_b = in_sign_b;
        sort_exp_a  = in_exponent_a;
        sort_exp_b  = in_exponent_b;
        sort_frac_a = in_fraction_a;
        sort_frac_b = in_fraction_b;
        if (exchange) begin
            sort_sign_a = in_sign_b;
            sort_sign_b = in_sign_a;
            sort_exp_a  = in_exponent_b;
            sort_exp_b  = in_exponent_a;
            sort_frac_a = in_fraction_b;
            sort_frac_b = in_fraction_a;
        end
    end

    // Stage 1: capture the sorted pair. Flush wins over a simultaneous accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_exchanged  <= 1'b0;
            s1_sign_a     <= 1'b0;
            s1_sign_b     <= 1'b0;
            s1_exponent   <= '0;
            s1_exp_diff   <= '0;
            s1_fraction_a <= '0;
            s1_fraction_b <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
            if (accept && !flush) begin
                s1_exchanged  <= exchange;
                s1_sign_a     <= sort_sign_a;
                s1_sign_b     <= sort_sign_b;
                s1_exponent   <= sort_exp_a;
                s1_exp_diff   <= sort_exp_a - sort_exp_b;
                s1_fraction_a <= sort_frac_a;
                s1_fraction_b <= sort_frac_b;
            end
        end
    end

    // Alignment of the smaller fraction
    logic [EXT_WIDTH-1:0] ext_b;
    logic [EXT_WIDTH-1:0] shifted_b;
    logic [EXT_WIDTH-1:0] aligned_b;

    always_comb begin
        ext_b     = {s1_fraction_b, 3'b000};
        shifted_b = '0;
        if (32'(s1_exp_diff) < EXT_WIDTH) begin
            shifted_b = ext_b >> s1_exp_diff;
        end
    end

`ifdef ALIGNER_STICKY_EN
    // Mask of the bit positions that fall off the right end. It is all ones once diff >= EXT_WIDTH.
    logic [EXT_WIDTH-1:0] lost_mask;

    always_comb begin
        lost_mask = ~({EXT_WIDTH{1'b1}} << s1_exp_diff);
        aligned_b = {shifted_b[EXT_WIDTH-1:1], shifted_b[0] | (|(ext_b & lost_mask))};
    end
`else
    assign aligned_b = shifted_b;
`endif

    // Stage 2: the output register holds its value while the downstream side stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_exchanged  <= 1'b0;
            out_sign_a     <= 1'b0;
            out_exponent   <= '0;
            out_fraction_a <= '0;
            out_sign_b     <= 1'b0;
            out_fraction_b <= '0;
            out_exp_diff   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (advance) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (advance && !flush) begin
                out_exchanged  <= s1_exchanged;
                out_sign_a     <= s1_sign_a;
                out_exponent   <= s1_exponent;
                out_fraction_a <= {s1_fraction_a, 3'b000};
                out_sign_b     <= s1_sign_b;
                out_fraction_b <= aligned_b;
                out_exp_diff   <= s1_exp_diff;
            end
        end
    end

endmodule

// File: tb/tb_aligner_exchange_shift_pipe.sv
// Scoreboard bench for aligner_exchange_shift_pipe (default parameters).
module tb_aligner_exchange_shift_pipe;

    localparam int unsigned EW = 8;
    localparam int unsigned FW = 24;
    localparam int unsigned XW = 27;

`ifdef ALIGNER_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign_a;
    logic [EW-1:0] in_exponent_a;
    logic [FW-1:0] in_fraction_a;
    logic          in_sign_b;
    logic [EW-1:0] in_exponent_b;
    logic [FW-1:0] in_fraction_b;
    logic          out_valid;
    logic          out_ready;
    logic          out_exchanged;
    logic          out_sign_a;
    logic [EW-1:0] out_exponent;
    logic [XW-1:0] out_fraction_a;
    logic          out_sign_b;
    logic [XW-1:0] out_fraction_b;
    logic [EW-1:0] out_exp_diff;

    aligner_exchange_shift_pipe dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_sign_a      (in_sign_a),
        .in_exponent_a  (in_exponent_a),
        .in_fraction_a  (in_fraction_a),
        .in_sign_b      (in_sign_b),
        .in_exponent_b  (in_exponent_b),
        .in_fraction_b  (in_fraction_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_exchanged  (out_exchanged),
        .out_sign_a     (out_sign_a),
        .out_exponent   (out_exponent),
        .out_fraction_a (out_fraction_a),
        .out_sign_b     (out_sign_b),
        .out_fraction_b (out_fraction_b),
        .out_exp_diff   (out_exp_diff)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          exch;
        logic          sa;
        logic [EW-1:0] e;
        logic [XW-1:0] fa;
        logic          sb;
        logic [XW-1:0] fb;
        logic [EW-1:0] d;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic exch, input logic sa, input logic [EW-1:0] e,
                                input logic [XW-1:0] fa, input logic sb,
                                input logic [XW-1:0] fb, input logic [EW-1:0] d);
        exp_t r;
        r.exch = exch; r.sa = sa; r.e = e; r.fa = fa; r.sb = sb; r.fb = fb; r.d = d;
        return r;
    endfunction

    // Monitor: pops the next expected result on every completed output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got exponent 0x%0h fraction_b 0x%0h, expected no output",
                         out_exponent, out_fraction_b);
            end else begin
                e = sb_q.pop_front();
                check("exchanged", 64'(out_exchanged),  64'(e.exch));
                check("sign_a",    64'(out_sign_a),     64'(e.sa));
                check("exponent",  64'(out_exponent),   64'(e.e));
                check("fraction_a",64'(out_fraction_a), 64'(e.fa));
                check("sign_b",    64'(out_sign_b),     64'(e.sb));
                check("fraction_b",64'(out_fraction_b), 64'(e.fb));
                check("exp_diff",  64'(out_exp_diff),   64'(e.d));
            end
        end
    end

    task automatic drive(input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                         input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb);
        in_sign_a = sa; in_exponent_a = ea; in_fraction_a = fa;
        in_sign_b = sb; in_exponent_b = eb; in_fraction_b = fb;
    endtask

    // Offer one pair. The task returns #1 after the accepting edge. The expected result is queued only when push is set.
    task automatic send(input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                        input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb,
                        input bit push, input exp_t ex);
        bit accepted = 1'b0;
        drive(sa, ea, fa, sb, eb, fb);
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            accepted = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end else if (push) begin
            sb_q.push_back(ex);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fraction_a", 64'(out_fraction_a), 64'd0);
        check("rst_fraction_b", 64'(out_fraction_b), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Swap by exponent, with a latency check
        send(0, 8'd10, 24'h800000, 1, 8'd12, 24'hC00000, 1,
             mk(1, 1, 8'd12, 27'h6000000, 0, 27'h1000000, 8'd2));
        @(negedge clk);
        check("latency_c1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_c2_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Back-to-back directed vectors
        send(0, 8'd5, 24'h900000, 0, 8'd5, 24'hA00000, 1,
             mk(1, 0, 8'd5, 27'h5000000, 0, 27'h4800000, 8'd0));
        send(1, 8'd7, 24'hC00000, 0, 8'd7, 24'hC00000, 1,
             mk(0, 1, 8'd7, 27'h6000000, 0, 27'h6000000, 8'd0));
        send(0, 8'd40, 24'h800000, 0, 8'd10, 24'h800001, 1,
             mk(0, 0, 8'd40, 27'h4000000, 0, 27'(STK), 8'd30));
        send(0, 8'd20, 24'hFFFFFF, 1, 8'd14, 24'h800004, 1,
             mk(0, 0, 8'd20, 27'h7FFFFF8, 1, 27'h100000 | 27'(STK), 8'd6));
        send(0, 8'd26, 24'h800000, 1, 8'd0, 24'h800000, 1,
             mk(0, 0, 8'd26, 27'h4000000, 1, 27'h1, 8'd26));
        send(1, 8'd27, 24'h800000, 0, 8'd0, 24'h800000, 1,
             mk(0, 1, 8'd27, 27'h4000000, 0, 27'(STK), 8'd27));
        send(1, 8'd0, 24'h123456, 0, 8'd255, 24'hFFFFFF, 1,
             mk(1, 0, 8'd255, 27'h7FFFFF8, 1, 27'(STK), 8'd255));
        drain();

        // Backpressure: the pipe holds two pairs, then in_ready drops
        out_ready = 1'b0;
        drive(0, 8'd3, 24'h800000, 0, 8'd1, 24'hC00000);
        in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready1", 64'(in_ready), 64'd1);
        sb_q.push_back(mk(0, 0, 8'd3, 27'h4000000, 0, 27'h1800000, 8'd2));
        @(posedge clk); #1;
        drive(0, 8'd1, 24'hC00000, 1, 8'd3, 24'h800000);
        @(negedge clk);
        check("bp_ready2", 64'(in_ready), 64'd1);
        sb_q.push_back(mk(1, 1, 8'd3, 27'h4000000, 0, 27'h1800000, 8'd2));
        @(posedge clk); #1;
        drive(1, 8'd50, 24'hABCDEF, 0, 8'd50, 24'hABCDEE);
        @(negedge clk);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_full_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(1, 8'd50, 24'hABCDEF, 0, 8'd50, 24'hABCDEE, 1,
             mk(0, 1, 8'd50, 27'h55E6F78, 0, 27'h55E6F70, 8'd0));
        @(negedge clk);
        check("bp_stream2", 64'(out_valid), 64'd1);
        @(negedge clk);
        check("bp_stream3", 64'(out_valid), 64'd1);
        drain();

        // Flush with two pairs in flight and a third pair offered in the flush cycle
        out_ready = 1'b0;
        send(0, 8'd9, 24'h800000, 0, 8'd4, 24'h800000, 0, '0);
        send(0, 8'd8, 24'h800000, 0, 8'd4, 24'h800000, 0, '0);
        drive(0, 8'd7, 24'h800000, 0, 8'd4, 24'h800000);
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        // Flush into an empty pipe while a pair is offered: the pair must be dropped
        @(posedge clk); #1;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("flush_quiet", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset while a result is presented
        out_ready = 1'b0;
        send(1, 8'd30, 24'hF00000, 1, 8'd28, 24'h900000, 0, '0);
        @(posedge clk); #1;
        check("mid_valid_before", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_exponent", 64'(out_exponent), 64'd0);
        check("mid_rst_fraction_a", 64'(out_fraction_a), 64'd0);
        check("mid_rst_fraction_b", 64'(out_fraction_b), 64'd0);
        check("mid_rst_exp_diff", 64'(out_exp_diff), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(0, 8'd2, 24'h800000, 1, 8'd3, 24'h800000, 1,
             mk(1, 1, 8'd3, 27'h4000000, 0, 27'h2000000, 8'd1));
        @(negedge clk);
        check("post_rst_c1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("post_rst_c2_valid", 64'(out_valid), 64'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aligner_exchange_shift_pipe.md
Name: aligner_exchange_shift_pipe

Overview:
- Parametrised, pipelined successor to the aligner's combinational operand-exchange stage.
- Orders two unpacked operands by magnitude (larger exponent, then larger fraction, becomes A) and computes the exponent difference.
- Right-aligns the smaller fraction with guard/round/sticky bits.
- Sits between the unpacker and the add/sub core, with valid/ready handshakes on both sides.

Parameters:
- EXP_WIDTH, 8, exponent field width; exponents treated as unsigned.
- FRAC_WIDTH, 24, fraction width including hidden bit.
- EXT_WIDTH, FRAC_WIDTH+3, aligned fraction width: fraction plus guard, round, sticky. Derived; do not override.

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; invalidates both pipeline stages
- in_valid  input  1  operand pair valid
- in_ready  output  1  stage can accept a pair this cycle
- in_sign_a  input  1  operand A sign
- in_exponent_a  input  EXP_WIDTH  operand A exponent
- in_fraction_a  input  FRAC_WIDTH  operand A fraction
- in_sign_b  input  1  operand B sign
- in_exponent_b  input  EXP_WIDTH  operand B exponent
- in_fraction_b  input  FRAC_WIDTH  operand B fraction
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_exchanged  output  1  operands were swapped
- out_sign_a  output  1  larger-magnitude sign
- out_exponent  output  EXP_WIDTH  larger exponent (result exponent)
- out_fraction_a  output  EXT_WIDTH  larger fraction, left-justified, low 3 bits zero
- out_sign_b  output  1  smaller-magnitude sign
- out_fraction_b  output  EXT_WIDTH  smaller fraction shifted right by the exponent difference; LSB is sticky
- out_exp_diff  output  EXP_WIDTH  exponent difference, unsigned

Behaviour:
- Reset (asynchronous, active-high): both stage valids = 0; out_valid = 0; all data outputs = 0; in_ready = 1 after release.
- Stage 1 (compare/exchange), registered:
  - exchange = (exp_b > exp_a) || (exp_b == exp_a && frac_b > frac_a). Equal magnitudes: no exchange.
  - Registers the sorted sign/exponent/fraction pair, the exchange flag, and diff = exp_A_sorted − exp_B_sorted. Diff never underflows.
- Stage 2 (align), registered:
  - ext_b = {frac_B_sorted, 3'b000}, shifted right by diff.
  - If diff ≥ EXT_WIDTH: shifted value = 0.
  - Bit 0 of out_fraction_b = OR of every bit shifted out, OR'd with bit 0 of the shifted value (see Optional Feature).
  - out_fraction_a = {frac_A_sorted, 3'b000}.
- Latency: 2 cycles from in_valid && in_ready to out_valid, when there is no backpressure. Throughput: 1 pair per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - stage2_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || stage2_ready (combinational, no skid buffer).
  - Output data and out_valid stay stable while out_valid && !out_ready.
- Capacity: 2 pairs. With out_ready held low, in_ready deasserts once both stages are full. Order is preserved and no pair is dropped or duplicated.
- flush: on the next edge both valids = 0. Input offered in the flush cycle is discarded; in_ready still reads per the rule above. flush has priority over a simultaneous accept.
- Reset mid-operation: in-flight pairs are lost and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: ALIGNER_STICKY_EN.
- Defined: sticky computed as in Behaviour; out_fraction_b[0] reflects every shifted-out bit.
- Undefined: no sticky logic; out_fraction_b[0] is plain bit 0 of the shifted value (truncation). Guard and round bits are still produced.

Test Plan (defaults EXP_WIDTH=8, FRAC_WIDTH=24, EXT_WIDTH=27):
- Swap by exponent: A exp=10 frac=0x800000, B exp=12 frac=0xC00000 → after 2 cycles: out_exchanged=1, out_exponent=12, out_exp_diff=2, out_fraction_a=0x6000000, out_fraction_b=0x1000000.
- Swap on equal exponent: exp 5/5, frac_a=0x900000, frac_b=0xA00000 → out_exchanged=1, diff=0, out_fraction_b=0x4800000. Identical operands → out_exchanged=0.
- Far shift: A exp=40 frac=0x800000, B exp=10 frac=0x800001 → diff=30, out_fraction_b=0x0000001 with ALIGNER_STICKY_EN; 0x0000000 without.
- Backpressure: out_ready=0, 3 back-to-back valid inputs → first 2 accepted, in_ready=0 on the third. Raise out_ready → all 3 emerge in order, one per cycle.
- Flush: 2 pairs in flight, flush pulsed 1 cycle → out_valid=0 next cycle, in_ready=1, nothing emitted afterwards.
- Reset mid-stream: assert reset between edges with out_valid=1 → out_valid and data outputs 0 immediately. After release, first new pair appears 2 cycles after acceptance.
